// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort frame collector.
package sort_pkg;

  localparam int N_DEFAULT     = 6;
  localparam int WIDTH_DEFAULT = 8;

  typedef logic [WIDTH_DEFAULT-1:0] elem_t;

  // Lifecycle of one frame buffer: written slot by slot, then held until consumed.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_t;

endpackage

// File: rtl/sort_frame_collector_frame_buffer.sv
// One frame buffer of the collector: element storage, fill state, real-element
// count and all-ones padding used when a partial frame is closed early.
module frame_buffer
  import sort_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(N)-1:0]       wr_idx,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       close,
  input  logic                       rd_clr,
  output buf_state_t                 state,
  output logic [$clog2(N+1)-1:0]     count,
  output logic [WIDTH-1:0]           data [N]
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  buf_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [N];
  logic [WIDTH-1:0] mem_d [N];
  logic             wr_last;
  int               pad_from;

  assign wr_last = wr_en && (wr_idx == LAST_IDX);

  // Next-state: consume clears the buffer; otherwise accept a write and
  // optionally close a partial frame, padding the unwritten tail.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mem_d    = mem_q;
    pad_from = int'(wr_idx) + (wr_en ? 1 : 0);
    if (rd_clr) begin
      state_d = EMPTY;
      count_d = '0;
      for (int i = 0; i < N; i++) mem_d[i] = '0;
    end else if (state_q != FULL) begin
      if (wr_en) begin
        mem_d[wr_idx] = wr_data;
        count_d       = count_q + CW'(1);
        state_d       = wr_last ? FULL : FILLING;
      end
      // A write that completes the frame makes the close redundant.
      if (close && (state_q == FILLING) && !wr_last) begin
        state_d = FULL;
        for (int i = 0; i < N; i++) begin
          if (i >= pad_from) mem_d[i] = '1;
        end
      end
    end
  end

  // Buffer state, count and storage registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign state = state_q;
  assign count = count_q;

  // Storage is presented directly; the top gates it with frame_valid.
  always_comb begin
    for (int i = 0; i < N; i++) data[i] = mem_q[i];
  end

endmodule

// File: rtl/sort_frame_collector.sv
// Sort frame collector: gathers N upstream elements into ping-pong frame
// buffers and presents complete frames to a sorter stage in acceptance order.
// Optional feature: define COLLECT_FLUSH_EN to add a flush input that closes
// a partial frame early, padding the remaining slots with all-ones.
module sort_frame_collector
  import sort_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef COLLECT_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [WIDTH-1:0]           frame_data [N],
  output logic [$clog2(N+1)-1:0]     frame_count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  logic             fill_sel_q, fill_sel_d;
  logic             out_sel_q, out_sel_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;

  buf_state_t       state_a, state_b, fill_state, out_state;
  logic [CW-1:0]    count_a, count_b;
  logic [WIDTH-1:0] data_a [N];
  logic [WIDTH-1:0] data_b [N];

  logic             flush_w;
  logic             accept, close, complete, consume;

`ifdef COLLECT_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Handshake decode from registered buffer state only; frame_ready never
  // reaches s_ready combinationally.
  assign fill_state  = fill_sel_q ? state_b : state_a;
  assign out_state   = out_sel_q  ? state_b : state_a;
  assign s_ready     = (fill_state != FULL);
  assign accept      = s_valid && s_ready;
  assign close       = flush_w && (fill_state == FILLING);
  assign complete    = (accept && (wr_idx_q == LAST_IDX)) || close;
  assign frame_valid = (out_state == FULL);
  assign consume     = frame_valid && frame_ready;

  // Write pointer and buffer selects advance on frame completion / consumption.
  always_comb begin
    wr_idx_d   = wr_idx_q;
    fill_sel_d = fill_sel_q;
    out_sel_d  = out_sel_q;
    if (complete) begin
      wr_idx_d   = '0;
      fill_sel_d = ~fill_sel_q;
    end else if (accept) begin
      wr_idx_d = wr_idx_q + IW'(1);
    end
    if (consume) out_sel_d = ~out_sel_q;
  end

  // Control registers; reset returns filling and output to buffer A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q   <= '0;
      fill_sel_q <= 1'b0;
      out_sel_q  <= 1'b0;
    end else begin
      wr_idx_q   <= wr_idx_d;
      fill_sel_q <= fill_sel_d;
      out_sel_q  <= out_sel_d;
    end
  end

  frame_buffer #(.N(N), .WIDTH(WIDTH)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && !fill_sel_q),
    .wr_idx  (wr_idx_q),
    .wr_data (s_data),
    .close   (close && !fill_sel_q),
    .rd_clr  (consume && !out_sel_q),
    .state   (state_a),
    .count   (count_a),
    .data    (data_a)
  );

  frame_buffer #(.N(N), .WIDTH(WIDTH)) u_buf_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && fill_sel_q),
    .wr_idx  (wr_idx_q),
    .wr_data (s_data),
    .close   (close && fill_sel_q),
    .rd_clr  (consume && out_sel_q),
    .state   (state_b),
    .count   (count_b),
    .data    (data_b)
  );

  // Present the selected buffer only while it holds a frame; zeros otherwise.
  always_comb begin
    frame_count = '0;
    for (int i = 0; i < N; i++) frame_data[i] = '0;
    if (frame_valid) begin
      frame_count = out_sel_q ? count_b : count_a;
      for (int i = 0; i < N; i++) frame_data[i] = out_sel_q ? data_b[i] : data_a[i];
    end
  end

endmodule

// File: tb/tb_sort_frame_collector.sv
// Testbench for sort_frame_collector: randomized and directed stimulus checked
// against a queue-based frame model. Flush tests run when COLLECT_FLUSH_EN is set.
module tb_sort_frame_collector;

  localparam int N = 6;
  localparam int W = 8;

  logic         clk, rst, s_valid, s_ready, frame_valid, frame_ready, flush;
  logic [W-1:0] s_data;
  logic [W-1:0] frame_data [N];
  logic [2:0]   frame_count;
  logic [N*W-1:0] dut_flat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] d [N];
    int           cnt;
  } frame_t;

  frame_t       fq[$];   // complete frames waiting to be consumed, oldest first
  logic [W-1:0] pq[$];   // elements of the frame currently being collected

  sort_frame_collector #(.N(N), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef COLLECT_FLUSH_EN
    .flush       (flush),
`endif
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) dut_flat[i*W +: W] = frame_data[i];
  end

  // Model view: at most two frames can be held, so input stalls only then.
  function automatic logic m_ready();
    return fq.size() < 2;
  endfunction

  function automatic logic m_valid();
    return fq.size() > 0;
  endfunction

  function automatic logic [2:0] m_count();
    return (fq.size() > 0) ? 3'(fq[0].cnt) : 3'd0;
  endfunction

  function automatic logic [N*W-1:0] m_flat();
    logic [N*W-1:0] r;
    r = '0;
    if (fq.size() > 0)
      for (int i = 0; i < N; i++) r[i*W +: W] = fq[0].d[i];
    return r;
  endfunction

  function automatic logic [N*W-1:0] ramp(input int base, input int step);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(base + step*i);
    return r;
  endfunction

  // Drive one cycle of inputs from the negedge, advance the model at the
  // posedge, and return at the following negedge for sampling.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic fr, input logic fl);
    logic acc, cons, pre_fill;
    frame_t f;
    s_valid = v; s_data = d; frame_ready = fr; flush = fl;
    acc      = v && m_ready();
    cons     = fr && m_valid();
    pre_fill = pq.size() > 0;
    @(posedge clk);
    if (cons) void'(fq.pop_front());
    if (acc) begin
      pq.push_back(d);
      if (pq.size() == N) begin
        for (int i = 0; i < N; i++) f.d[i] = pq[i];
        f.cnt = N;
        fq.push_back(f);
        pq.delete();
      end
    end
    if (fl && pre_fill && pq.size() > 0) begin
      for (int i = 0; i < N; i++) f.d[i] = (i < pq.size()) ? pq[i] : {W{1'b1}};
      f.cnt = pq.size();
      fq.push_back(f);
      pq.delete();
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; frame_ready = 1'b0; flush = 1'b0;
    fq.delete(); pq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; frame_ready = 1'b1; flush = 1'b0;
    fq.delete(); pq.delete();
    repeat (2) @(negedge clk);
    total++;
    if ({s_ready, frame_valid, frame_count, dut_flat} !== {1'b1, 1'b0, 3'd0, {N*W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_hold: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=1 vld=0 cnt=0 data=0",
               s_ready, frame_valid, frame_count, dut_flat);
    end
    s_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++;
    if ({s_ready, frame_valid, frame_count, dut_flat} !== {1'b1, 1'b0, 3'd0, {N*W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=1 vld=0 cnt=0 data=0",
               s_ready, frame_valid, frame_count, dut_flat);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    for (int k = 0; k < N; k++) begin
      drive(1'b1, W'(10*(k+1)), 1'b1, 1'b0);
      total++;
      if ({s_ready, frame_valid, frame_count, dut_flat} !== {m_ready(), m_valid(), m_count(), m_flat()}) begin
        bad++;
        $display("FAIL basic_cycle%0d: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=%b vld=%b cnt=%0d data=%h",
                 k, s_ready, frame_valid, frame_count, dut_flat, m_ready(), m_valid(), m_count(), m_flat());
      end
    end
    total++;
    if ({frame_valid, frame_count, dut_flat} !== {1'b1, 3'd6, ramp(10, 10)}) begin
      bad++;
      $display("FAIL basic_frame: got vld=%b cnt=%0d data=%h, want vld=1 cnt=6 data=%h",
               frame_valid, frame_count, dut_flat, ramp(10, 10));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    total++;
    if ({frame_valid, frame_count, dut_flat} !== {1'b0, 3'd0, {N*W{1'b0}}}) begin
      bad++;
      $display("FAIL basic_after: got vld=%b cnt=%0d data=%h, want vld=0 cnt=0 data=0",
               frame_valid, frame_count, dut_flat);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int k = 0; k < 2*N; k++) drive(1'b1, W'(100+k), 1'b0, 1'b0);
    total++;
    if ({s_ready, frame_valid, dut_flat} !== {1'b0, 1'b1, ramp(100, 1)}) begin
      bad++;
      $display("FAIL bp_both_full: got rdy=%b vld=%b data=%h, want rdy=0 vld=1 data=%h",
               s_ready, frame_valid, dut_flat, ramp(100, 1));
    end
    drive(1'b1, 8'd200, 1'b0, 1'b0);
    total++;
    if ({s_ready, frame_valid, frame_count, dut_flat} !== {m_ready(), m_valid(), m_count(), m_flat()}) begin
      bad++;
      $display("FAIL bp_stall: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=%b vld=%b cnt=%0d data=%h",
               s_ready, frame_valid, frame_count, dut_flat, m_ready(), m_valid(), m_count(), m_flat());
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    total++;
    if ({s_ready, frame_valid, frame_count, dut_flat} !== {1'b1, 1'b1, 3'd6, ramp(106, 1)}) begin
      bad++;
      $display("FAIL bp_first_consume: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=1 vld=1 cnt=6 data=%h",
               s_ready, frame_valid, frame_count, dut_flat, ramp(106, 1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    total++;
    if ({s_ready, frame_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_drained: got rdy=%b vld=%b, want rdy=1 vld=0", s_ready, frame_valid);
    end
  endtask

  task automatic test_stream();
    int nvalid = 0;
    int nready_low = 0;
    apply_reset();
    for (int k = 0; k < 10*N; k++) begin
      if (s_ready !== 1'b1) nready_low++;
      drive(1'b1, W'($urandom), 1'b1, 1'b0);
      if (frame_valid === 1'b1) nvalid++;
      total++;
      if ({s_ready, frame_valid, frame_count, dut_flat} !== {m_ready(), m_valid(), m_count(), m_flat()}) begin
        bad++;
        $display("FAIL stream_cycle%0d: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=%b vld=%b cnt=%0d data=%h",
                 k, s_ready, frame_valid, frame_count, dut_flat, m_ready(), m_valid(), m_count(), m_flat());
      end
    end
    total++;
    if (nvalid != 10 || nready_low != 0) begin
      bad++;
      $display("FAIL stream_totals: got frames=%0d ready_low=%0d, want frames=10 ready_low=0",
               nvalid, nready_low);
    end
  endtask

  task automatic test_hold();
    apply_reset();
    for (int k = 0; k < 2*N; k++) drive(1'b1, W'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, W'($urandom), logic'(k % 2), 1'b0);
      total++;
      if ({s_ready, frame_valid, frame_count, dut_flat} !== {m_ready(), m_valid(), m_count(), m_flat()}) begin
        bad++;
        $display("FAIL hold_cycle%0d: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=%b vld=%b cnt=%0d data=%h",
                 k, s_ready, frame_valid, frame_count, dut_flat, m_ready(), m_valid(), m_count(), m_flat());
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int k = 0; k < N+3; k++) drive(1'b1, W'(50+k), 1'b0, 1'b0);
    rst = 1'b1;
    fq.delete(); pq.delete();
    #1;
    total++;
    if ({s_ready, frame_valid, frame_count, dut_flat} !== {1'b1, 1'b0, 3'd0, {N*W{1'b0}}}) begin
      bad++;
      $display("FAIL midreset_async: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=1 vld=0 cnt=0 data=0",
               s_ready, frame_valid, frame_count, dut_flat);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= N; k++) drive(1'b1, W'(k), 1'b0, 1'b0);
    total++;
    if ({frame_valid, frame_count, dut_flat} !== {1'b1, 3'd6, ramp(1, 1)}) begin
      bad++;
      $display("FAIL midreset_frame: got vld=%b cnt=%0d data=%h, want vld=1 cnt=6 data=%h",
               frame_valid, frame_count, dut_flat, ramp(1, 1));
    end
  endtask

  task automatic test_random();
    logic fl;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      fl = 1'b0;
`ifdef COLLECT_FLUSH_EN
      fl = ($urandom_range(0, 7) == 0);
`endif
      drive(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0), fl);
      total++;
      if ({s_ready, frame_valid, frame_count, dut_flat} !== {m_ready(), m_valid(), m_count(), m_flat()}) begin
        bad++;
        $display("FAIL random_cycle%0d: got rdy=%b vld=%b cnt=%0d data=%h, want rdy=%b vld=%b cnt=%0d data=%h",
                 k, s_ready, frame_valid, frame_count, dut_flat, m_ready(), m_valid(), m_count(), m_flat());
      end
    end
  endtask

`ifdef COLLECT_FLUSH_EN
  task automatic test_flush();
    logic [N*W-1:0] exp;
    apply_reset();
    drive(1'b1, 8'd7, 1'b0, 1'b0);
    drive(1'b1, 8'd8, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    exp = {N*W{1'b1}};
    exp[0 +: W] = 8'd7;
    exp[W +: W] = 8'd8;
    total++;
    if ({frame_valid, frame_count, dut_flat} !== {1'b1, 3'd2, exp}) begin
      bad++;
      $display("FAIL flush_partial: got vld=%b cnt=%0d data=%h, want vld=1 cnt=2 data=%h",
               frame_valid, frame_count, dut_flat, exp);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    total++;
    if ({s_ready, frame_valid, frame_count} !== {1'b1, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL flush_empty: got rdy=%b vld=%b cnt=%0d, want rdy=1 vld=0 cnt=0",
               s_ready, frame_valid, frame_count);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; frame_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_hold();
    test_mid_reset();
`ifdef COLLECT_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_frame_collector.md
SORT_FRAME_COLLECTOR -- requirements
Module: sort_frame_collector

Interface
REQ-001 Parameter N, default 6, elements per frame (N >= 2).
REQ-002 Parameter WIDTH, default 8, bits per element.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  upstream element valid.
REQ-006 s_ready  output  1  collector can accept an element this cycle.
REQ-007 s_data  input  WIDTH  upstream element, unsigned.
REQ-008 frame_valid  output  1  a complete frame is presented.
REQ-009 frame_ready  input  1  sorter stage consumes the frame.
REQ-010 frame_data  output  N x WIDTH unpacked array  frame elements, index 0 = first accepted; feeds the sorter data_in directly.
REQ-011 frame_count  output  $clog2(N+1)  number of real (non-pad) elements in the presented frame.

Function
REQ-012 The block SHALL hold two frame buffers (A, B), each in state EMPTY, FILLING or FULL.
REQ-013 s_ready SHALL be high exactly when the current fill buffer is not FULL; it is a registered-state decode, with no combinational path from frame_ready.
REQ-014 On s_valid && s_ready, s_data SHALL be written to fill-buffer index wr_idx and wr_idx SHALL increment; first write moves EMPTY->FILLING.
REQ-015 When the write at wr_idx = N-1 occurs, the buffer SHALL go FULL, wr_idx SHALL wrap to 0, and fill SHALL switch to the other buffer.
REQ-016 frame_valid SHALL be high whenever the output-select buffer is FULL; output select starts at A and alternates, so frames leave in acceptance order.
REQ-017 Latency: last element accepted at edge t -> frame_valid high in the cycle after edge t.
REQ-018 On frame_valid && frame_ready, the output buffer SHALL become EMPTY and output select SHALL toggle at that edge.
REQ-019 frame_data and frame_count SHALL remain stable while frame_valid && !frame_ready.
REQ-020 Simultaneous completion of one buffer and consumption of the other SHALL leave s_ready high the next cycle; sustained s_valid = frame_ready = 1 gives one element per cycle, no bubbles.
REQ-021 Both buffers FULL SHALL force s_ready low until a frame is consumed; no element is ever dropped or overwritten.
REQ-022 frame_data SHALL be all zeros and frame_count SHALL be 0 when frame_valid is low.

Reset
REQ-023 rst SHALL immediately set both buffers EMPTY, wr_idx = 0, fill = A, output select = A, all storage to 0.
REQ-024 While rst is high and after release: frame_valid = 0, frame_count = 0, frame_data = 0, s_ready = 1.
REQ-025 rst mid-frame SHALL discard all partial and full frames; no frame emitted after reset contains pre-reset data.

Configuration
REQ-026 Macro COLLECT_FLUSH_EN SHALL add input port flush (1 bit).
REQ-027 With COLLECT_FLUSH_EN: flush high at an edge while the fill buffer is FILLING SHALL close it as FULL, fill slots wr_idx..N-1 with all-ones (sort to the top), set its frame_count = elements written, wrap wr_idx and switch fill.
REQ-028 An element accepted at the same edge as flush SHALL be included before padding; if that write completes the frame, flush has no further effect; flush with fill buffer EMPTY SHALL be ignored.
REQ-029 Without COLLECT_FLUSH_EN: no flush port; frame_count SHALL equal N whenever frame_valid is high.

Structure
REQ-030 Package sort_pkg SHALL hold default N and WIDTH constants, elem_t (logic [WIDTH-1:0]) and buf_state_t enum {EMPTY, FILLING, FULL}.
REQ-031 Sub-module frame_buffer (storage, state, count, pad logic for one buffer) SHALL be instantiated twice; the top holds wr_idx, fill/output select and handshakes.

Verification
REQ-032 Reset release, s_valid = 1, data 10,20,30,40,50,60 one per cycle, frame_ready = 1 -> frame_valid for one cycle after last accept, frame_data = {10,20,30,40,50,60}, frame_count = 6.
REQ-033 frame_ready = 0, stream 12 elements -> both frames FULL, s_ready low from the 13th cycle; release frame_ready -> frames 1 and 2 emitted in order, s_ready returns high after first consume.
REQ-034 Continuous stream of 60 elements with frame_ready = 1 -> 10 frames, s_ready never low, element order preserved.
REQ-035 frame_ready toggling every cycle during a held frame -> frame_data unchanged until the handshake edge.
REQ-036 Assert rst after 3 elements accepted -> frame_valid = 0; next 6 elements {1..6} form a clean frame {1,2,3,4,5,6}.
REQ-037 COLLECT_FLUSH_EN: accept 7,8 then flush -> frame_data = {7,8,FF,FF,FF,FF}, frame_count = 2; flush when EMPTY -> no frame.
